// File: rtl/clk_div_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master side issues ratio loads and phase strobes. The slave side returns the divided outputs.
interface clk_div_prog_if #(
  parameter int DIV_WIDTH = 8
);
  logic [DIV_WIDTH-1:0] div_value;
  logic                 div_load;
  logic                 bit_slip;
  logic                 sync;
  logic                 clk_out;
  logic                 ce_out;
  logic [DIV_WIDTH-1:0] div_active;
  logic                 div_err;

  modport master (
    output div_value, div_load, bit_slip, sync,
    input  clk_out, ce_out, div_active, div_err
  );

  modport slave (
    input  div_value, div_load, bit_slip, sync,
    output clk_out, ce_out, div_active, div_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable fabric clock divider with staged ratio changes, bit-slip and multi-divider SYNC.
// Every output is registered from next state, so no input reaches an output combinationally.
module clk_div_prog #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic           clk_in,
  input  logic           rst,
  clk_div_prog_if.slave  bus
);
  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic [DIV_WIDTH-1:0] div_act, div_pend, n_nxt, half_nxt;
  logic                 pend_v, legal, wrap, apply, hold;
  logic                 clk_q, ce_q, err_q;

  always_comb begin
    legal   = bus.div_value >= DIV_WIDTH'(2);
    wrap    = cnt == (div_act - DIV_WIDTH'(1));
    apply   = 1'b0;
    hold    = 1'b0;
    cnt_nxt = cnt + DIV_WIDTH'(1);
    if (bus.sync) begin
      cnt_nxt = '0;
      apply   = 1'b1;
    end else if (bus.bit_slip) begin
      cnt_nxt = cnt;
      hold    = 1'b1;
    end else if (wrap) begin
      cnt_nxt = '0;
      apply   = 1'b1;
    end
    // A staged ratio takes over only at a period boundary, so no period is truncated.
    n_nxt    = (apply && pend_v) ? div_pend : div_act;
    half_nxt = n_nxt >> 1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt      <= DEF - DIV_WIDTH'(1);
      div_act  <= DEF;
      div_pend <= DEF;
      pend_v   <= 1'b0;
      clk_q    <= 1'b0;
      ce_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div_act <= n_nxt;
      clk_q   <= cnt_nxt < half_nxt;
      // A slip that holds phase 0 must not produce a second CE pulse.
      ce_q    <= (cnt_nxt == '0) && !hold;
      err_q   <= bus.div_load && !legal;
      if (bus.div_load && legal) begin
        div_pend <= bus.div_value;
        pend_v   <= 1'b1;
      end else if (apply) begin
        pend_v   <= 1'b0;
      end
    end
  end

  assign bus.clk_out    = clk_q;
  assign bus.ce_out     = ce_q;
  assign bus.div_active = div_act;
  assign bus.div_err    = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog. Two instances make the SYNC alignment and slip-versus-reference checks possible.
module tb_clk_div_prog;
  logic clk = 1'b0;
  logic rst0, rst1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  clk_div_prog_if #(.DIV_WIDTH(8)) b0 ();
  clk_div_prog_if #(.DIV_WIDTH(8)) b1 ();

  clk_div_prog #(.DIV_WIDTH(8), .DEFAULT_DIV(4)) u0 (.clk_in(clk), .rst(rst0), .bus(b0));
  clk_div_prog #(.DIV_WIDTH(8), .DEFAULT_DIV(4)) u1 (.clk_in(clk), .rst(rst1), .bus(b1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    b0.div_load = 1'b0; b0.bit_slip = 1'b0; b0.sync = 1'b0;
    b1.div_load = 1'b0; b1.bit_slip = 1'b0; b1.sync = 1'b0;
  endtask

  task automatic test_reset;
    logic ec, ek;
    rst0 = 1'b1; rst1 = 1'b1;
    b0.div_value = 8'd0; b1.div_value = 8'd0;
    idle();
    tick(); tick();
    total++;
    if (b0.ce_out !== 1'b0 || b0.clk_out !== 1'b0 || b0.div_err !== 1'b0) begin
      bad++; $display("FAIL reset_outs got ce=%b clk=%b err=%b want 0 0 0", b0.ce_out, b0.clk_out, b0.div_err);
    end
    total++;
    if (b0.div_active !== 8'd4) begin
      bad++; $display("FAIL reset_active got=%0d want=4", b0.div_active);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      ec = (i % 4) == 0;
      ek = (i % 4) < 2;
      total++;
      if (b0.ce_out !== ec || b0.clk_out !== ek) begin
        bad++; $display("FAIL reset_pattern[%0d] got ce=%b clk=%b want ce=%b clk=%b", i, b0.ce_out, b0.clk_out, ec, ek);
      end
    end
    total++;
    if (b0.div_active !== 8'd4) begin
      bad++; $display("FAIL reset_active_run got=%0d want=4", b0.div_active);
    end
  endtask

  task automatic test_load;
    logic ec, ek;
    tick(); // phase 0
    tick(); // phase 1
    b0.div_value = 8'd7; b0.div_load = 1'b1;
    tick(); b0.div_load = 1'b0; // phase 2
    tick();                     // phase 3
    total++;
    if (b0.div_active !== 8'd4 || b0.ce_out !== 1'b0) begin
      bad++; $display("FAIL load_before_wrap got act=%0d ce=%b want act=4 ce=0", b0.div_active, b0.ce_out);
    end
    tick();
    total++;
    if (b0.div_active !== 8'd7 || b0.ce_out !== 1'b1 || b0.clk_out !== 1'b1) begin
      bad++; $display("FAIL load_at_wrap got act=%0d ce=%b clk=%b want 7 1 1", b0.div_active, b0.ce_out, b0.clk_out);
    end
    for (int i = 1; i < 14; i++) begin
      tick();
      ec = (i % 7) == 0;
      ek = (i % 7) < 3;
      total++;
      if (b0.ce_out !== ec || b0.clk_out !== ek) begin
        bad++; $display("FAIL div7_pattern[%0d] got ce=%b clk=%b want ce=%b clk=%b", i, b0.ce_out, b0.clk_out, ec, ek);
      end
    end
    // phase 6: this load coincides with a wrap and must wait one more period
    b0.div_value = 8'd4; b0.div_load = 1'b1;
    tick(); b0.div_load = 1'b0;
    total++;
    if (b0.div_active !== 8'd7 || b0.ce_out !== 1'b1) begin
      bad++; $display("FAIL load_on_wrap got act=%0d ce=%b want act=7 ce=1", b0.div_active, b0.ce_out);
    end
    repeat (6) tick();
    total++;
    if (b0.div_active !== 8'd7 || b0.ce_out !== 1'b0) begin
      bad++; $display("FAIL load_on_wrap_hold got act=%0d ce=%b want act=7 ce=0", b0.div_active, b0.ce_out);
    end
    tick();
    total++;
    if (b0.div_active !== 8'd4 || b0.ce_out !== 1'b1) begin
      bad++; $display("FAIL load_on_wrap_apply got act=%0d ce=%b want act=4 ce=1", b0.div_active, b0.ce_out);
    end
  endtask

  task automatic test_err;
    b0.div_value = 8'd0; b0.div_load = 1'b1;
    tick(); b0.div_load = 1'b0;
    total++;
    if (b0.div_err !== 1'b1) begin
      bad++; $display("FAIL err_zero got=%b want=1", b0.div_err);
    end
    tick();
    total++;
    if (b0.div_err !== 1'b0) begin
      bad++; $display("FAIL err_zero_clear got=%b want=0", b0.div_err);
    end
    b0.div_value = 8'd1; b0.div_load = 1'b1;
    tick(); b0.div_load = 1'b0;
    total++;
    if (b0.div_err !== 1'b1) begin
      bad++; $display("FAIL err_one got=%b want=1", b0.div_err);
    end
    tick();
    total++;
    if (b0.div_err !== 1'b0 || b0.ce_out !== 1'b1 || b0.div_active !== 8'd4) begin
      bad++; $display("FAIL err_one_after got err=%b ce=%b act=%0d want 0 1 4", b0.div_err, b0.ce_out, b0.div_active);
    end
    repeat (4) tick();
    total++;
    if (b0.ce_out !== 1'b1 || b0.div_active !== 8'd4) begin
      bad++; $display("FAIL err_no_stage got ce=%b act=%0d want ce=1 act=4", b0.ce_out, b0.div_active);
    end
  endtask

  task automatic test_sync;
    logic ec, ek;
    b0.div_value = 8'd5; b0.div_load = 1'b1;
    b1.div_value = 8'd5; b1.div_load = 1'b1;
    tick(); idle();
    repeat (10) tick();
    total++;
    if (b0.div_active !== 8'd5 || b1.div_active !== 8'd5) begin
      bad++; $display("FAIL sync_n5 got act0=%0d act1=%0d want 5 5", b0.div_active, b1.div_active);
    end
    b0.sync = 1'b1; b1.sync = 1'b1;
    tick(); idle();
    total++;
    if (b0.ce_out !== 1'b1 || b1.ce_out !== 1'b1 || b0.clk_out !== 1'b1 || b1.clk_out !== 1'b1) begin
      bad++; $display("FAIL sync_first got ce=%b%b clk=%b%b want 11 11", b0.ce_out, b1.ce_out, b0.clk_out, b1.clk_out);
    end
    for (int i = 1; i < 10; i++) begin
      tick();
      ec = (i % 5) == 0;
      ek = (i % 5) < 2;
      total++;
      if (b0.ce_out !== ec || b1.ce_out !== ec || b0.clk_out !== ek || b1.clk_out !== ek) begin
        bad++; $display("FAIL sync_aligned[%0d] got ce=%b%b clk=%b%b want ce=%b clk=%b", i, b0.ce_out, b1.ce_out, b0.clk_out, b1.clk_out, ec, ek);
      end
    end
    // phase 4: slip on the same edge as SYNC must be dropped
    b0.sync = 1'b1; b1.sync = 1'b1; b0.bit_slip = 1'b1;
    tick(); idle();
    total++;
    if (b0.ce_out !== 1'b1 || b1.ce_out !== 1'b1) begin
      bad++; $display("FAIL sync_slip_first got ce=%b%b want 11", b0.ce_out, b1.ce_out);
    end
    for (int i = 1; i < 10; i++) begin
      tick();
      ec = (i % 5) == 0;
      ek = (i % 5) < 2;
      total++;
      if (b0.ce_out !== ec || b1.ce_out !== ec || b0.clk_out !== ek || b1.clk_out !== ek) begin
        bad++; $display("FAIL sync_slip[%0d] got ce=%b%b clk=%b%b want ce=%b clk=%b", i, b0.ce_out, b1.ce_out, b0.clk_out, b1.clk_out, ec, ek);
      end
    end
    b0.div_value = 8'd4; b0.div_load = 1'b1;
    b1.div_value = 8'd4; b1.div_load = 1'b1;
    tick(); idle();
    total++;
    if (b0.div_active !== 8'd5 || b0.ce_out !== 1'b1) begin
      bad++; $display("FAIL sync_stage got act=%0d ce=%b want act=5 ce=1", b0.div_active, b0.ce_out);
    end
    b0.sync = 1'b1; b1.sync = 1'b1;
    tick(); idle();
    total++;
    if (b0.div_active !== 8'd4 || b1.div_active !== 8'd4 || b0.ce_out !== 1'b1) begin
      bad++; $display("FAIL sync_apply got act0=%0d act1=%0d ce=%b want 4 4 1", b0.div_active, b1.div_active, b0.ce_out);
    end
    repeat (3) tick();
    total++;
    if (b0.ce_out !== 1'b0 || b1.ce_out !== 1'b0) begin
      bad++; $display("FAIL sync_n4_mid got ce=%b%b want 00", b0.ce_out, b1.ce_out);
    end
    tick();
    total++;
    if (b0.ce_out !== 1'b1 || b1.ce_out !== 1'b1) begin
      bad++; $display("FAIL sync_n4_wrap got ce=%b%b want 11", b0.ce_out, b1.ce_out);
    end
  endtask

  task automatic test_bit_slip;
    int  n;
    logic found;
    for (int k = 0; k < 3; k++) begin
      b0.bit_slip = 1'b1;
      tick(); idle();
      total++;
      if (b0.ce_out !== 1'b0 || b0.clk_out !== 1'b1) begin
        bad++; $display("FAIL slip_hold[%0d] got ce=%b clk=%b want ce=0 clk=1", k, b0.ce_out, b0.clk_out);
      end
      n = 0; found = 1'b0;
      while (!found && n < 10) begin
        tick();
        n++;
        if (b0.ce_out === 1'b1) found = 1'b1;
      end
      total++;
      if (!found || n != 4) begin
        bad++; $display("FAIL slip_period[%0d] got=%0d want=5", k, n + 1);
      end
    end
    tick();
    total++;
    if (b1.ce_out !== 1'b1 || b0.ce_out !== 1'b0) begin
      bad++; $display("FAIL slip_offset got ref_ce=%b dut_ce=%b want ref_ce=1 dut_ce=0", b1.ce_out, b0.ce_out);
    end
  endtask

  task automatic test_rst_mid;
    int  n;
    logic found;
    n = 0; found = 1'b0;
    while (!found && n < 8) begin
      tick();
      n++;
      if (b0.ce_out === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rst_align got no ce within %0d cycles want ce", n);
    end
    tick(); // phase 1
    b0.div_value = 8'd9; b0.div_load = 1'b1;
    tick(); idle(); // phase 2, ratio 9 pending
    rst0 = 1'b1;
    tick();
    total++;
    if (b0.ce_out !== 1'b0 || b0.clk_out !== 1'b0 || b0.div_active !== 8'd4) begin
      bad++; $display("FAIL rst_mid_state got ce=%b clk=%b act=%0d want 0 0 4", b0.ce_out, b0.clk_out, b0.div_active);
    end
    rst0 = 1'b0;
    tick();
    total++;
    if (b0.ce_out !== 1'b1 || b0.clk_out !== 1'b1 || b0.div_active !== 8'd4) begin
      bad++; $display("FAIL rst_mid_first got ce=%b clk=%b act=%0d want 1 1 4", b0.ce_out, b0.clk_out, b0.div_active);
    end
    repeat (4) tick();
    total++;
    if (b0.ce_out !== 1'b1 || b0.div_active !== 8'd4) begin
      bad++; $display("FAIL rst_mid_pend_dropped got ce=%b act=%0d want ce=1 act=4", b0.ce_out, b0.div_active);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_err();
    test_sync();
    test_bit_slip();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Fabric clock divider for the digitizer clocking tree; successor to the fixed divide-by-4 clock-divider wrapper.
- Generates a registered divided square wave and a one-cycle clock-enable pulse from CLK_IN.
- Divide ratio is set at runtime. Ratio changes are staged so that no period is ever truncated.
- Adds bit-slip (phase retard by one input cycle) and a SYNC input that aligns several dividers.

Parameters:
- DIV_WIDTH, 8: width of the divide-ratio field; legal ratios are 2 .. 2^DIV_WIDTH-1.
- DEFAULT_DIV, 4: ratio in effect after reset. Must be within the legal range.

Ports:
- CLK_IN  in  1  input clock; all logic is on its rising edge.
- RST  in  1  synchronous reset, active-high.
- DIV_VALUE  in  DIV_WIDTH  requested divide ratio N.
- DIV_LOAD  in  1  single-cycle strobe that captures DIV_VALUE into the staging register.
- BIT_SLIP  in  1  single-cycle strobe that delays the output phase by one CLK_IN cycle.
- SYNC  in  1  single-cycle strobe that restarts the period at phase 0.
- CLK_OUT  out  1  registered divided clock. It is a fabric signal, not a global clock net.
- CE_OUT  out  1  one-cycle pulse on the CLK_IN cycle where CLK_OUT rises (phase 0).
- DIV_ACTIVE  out  DIV_WIDTH  ratio currently in effect.
- DIV_ERR  out  1  one-cycle pulse when DIV_LOAD is given an illegal value (0 or 1).

Behaviour:
- Internal state:
  - phase counter cnt, 0 .. N-1, where N = DIV_ACTIVE.
  - staging register div_pend with valid flag pend_v.
  - half = floor(N/2).
- Reset (RST=1 on an edge):
  - cnt=DEFAULT_DIV-1, DIV_ACTIVE=DEFAULT_DIV, pend_v=0.
  - CLK_OUT=0, CE_OUT=0, DIV_ERR=0.
  - The first edge with RST=0 wraps cnt to 0 and asserts CE_OUT=1 and CLK_OUT=1.
- Normal count: cnt_next = (cnt==N-1) ? 0 : cnt+1.
- Outputs are registered from next state:
  - CLK_OUT <= (cnt_next < half).
  - CE_OUT <= (cnt_next == 0).
  - Latency from any control strobe to an output change is 1 CLK_IN cycle.
- Duty cycle:
  - Even N: exactly 50%.
  - Odd N: high for floor(N/2) cycles, low for ceil(N/2) cycles.
  - Example: N=3 gives 1 cycle high, 2 cycles low.
- DIV_LOAD with DIV_VALUE >= 2:
  - div_pend <= DIV_VALUE, pend_v <= 1.
  - At the next natural wrap (cnt==N-1 -> 0), DIV_ACTIVE <= div_pend and pend_v <= 0.
  - The new N governs the period that starts at that wrap.
  - A second DIV_LOAD before the wrap overwrites div_pend; the last value wins.
- DIV_LOAD with DIV_VALUE < 2:
  - Value is ignored and DIV_ERR pulses for 1 cycle.
  - div_pend and pend_v are unchanged.
- DIV_LOAD on the same cycle as a wrap:
  - Takes effect at the following wrap, not the current one.
  - The wrap applies the previous pending value, if any.
- BIT_SLIP:
  - cnt holds its value for one extra cycle, so the current period is N+1 cycles.
  - CLK_OUT holds its level for that cycle; CE_OUT does not pulse during the hold.
- Multiple BIT_SLIP strobes accumulate, one extra cycle each.
- SYNC:
  - cnt_next=0, so CE_OUT=1 and CLK_OUT=1 on the next cycle, regardless of the current phase.
  - If pend_v=1, the pending ratio is applied at the SYNC, as if it were a wrap.
- Priority on the same cycle: RST > SYNC > BIT_SLIP > normal count.
  - SYNC together with BIT_SLIP: the slip is discarded.
  - SYNC together with DIV_LOAD: the SYNC applies the previous pending value. The newly loaded value is staged and applied at the next wrap.
- RST asserted mid-period:
  - Discards the pending ratio.
  - Restores DEFAULT_DIV on the next edge; no partial state survives.
- No combinational path from any input to any output.

Test Plan:
- Reset release, DEFAULT_DIV=4 -> CE_OUT pulses every 4 cycles starting at the first post-reset edge; CLK_OUT pattern 1,1,0,0 repeating; DIV_ACTIVE=4.
- DIV_LOAD with DIV_VALUE=7 at cnt=1 -> current period completes in 4 cycles, then 7-cycle periods with CLK_OUT 3 high / 4 low; DIV_ACTIVE changes exactly at the wrap.
- DIV_LOAD with DIV_VALUE=0, then a separate strobe with DIV_VALUE=1 -> DIV_ERR pulses once per strobe; period stays 4; DIV_ACTIVE stays 4.
- BIT_SLIP at N=4, issued three times in separate periods -> those periods measure 5 cycles; CE_OUT phase shifts by 3 cycles total versus an unslipped reference divider.
- Two dividers at N=5 with different phases, then a common SYNC -> both assert CE_OUT on the same following cycle and stay aligned; SYNC+BIT_SLIP on the same cycle -> no slip observed.
- RST asserted at cnt=2 with DIV_VALUE=9 pending -> after release N=4 (DEFAULT_DIV), pend_v cleared, first CE_OUT on the first post-reset edge.
